// File: rtl/cacode_sched_if.sv
// Control/status bundle between a channel's register block and its C/A code scheduler.
// The register block drives through the master modport; cacode_sched connects via slave.
interface cacode_sched_if #(
  parameter int unsigned NCO_W  = 32,
  parameter int unsigned SLEW_W = 10
);
  logic              cfg_we;
  logic [9:0]        cfg_init;
  logic              cfg_g2_init;
  logic              start;
  logic              stop;
  logic [NCO_W-1:0]  code_rate;
  logic              slew_req;
  logic [SLEW_W-1:0] slew_chips;
  logic              slew_busy;
  logic              cg_rst;
  logic              cg_g2_init;
  logic [9:0]        cg_init;
  logic              cg_rd;
  logic [9:0]        chip_idx;
  logic              epoch;
  logic [4:0]        ms_idx;
  logic              bit_edge;
  logic              running;

  modport master (
    output cfg_we, cfg_init, cfg_g2_init, start, stop, code_rate, slew_req, slew_chips,
    input  slew_busy, cg_rst, cg_g2_init, cg_init, cg_rd, chip_idx, epoch, ms_idx, bit_edge,
           running
  );

  modport slave (
    input  cfg_we, cfg_init, cfg_g2_init, start, stop, code_rate, slew_req, slew_chips,
    output slew_busy, cg_rst, cg_g2_init, cg_init, cg_rd, chip_idx, epoch, ms_idx, bit_edge,
           running
  );
endinterface

// File: rtl/cacode_sched.sv
// C/A code chip-rate scheduler: code NCO, generator reset/advance strobes and code-phase
// tracking (chip, 1 ms epoch, 20 ms bit edge), with whole-chip slewing by holding the code.
module cacode_sched #(
  parameter int unsigned NCO_W  = 32,
  parameter int unsigned SLEW_W = 10
) (
  input logic           clk,
  input logic           rst_n,
  cacode_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StSlew} state_e;

  state_e            state_q;
  logic [NCO_W-1:0]  acc_q;
  logic [NCO_W-1:0]  acc_sum;
  logic              carry;
  logic [SLEW_W-1:0] hold_q;
  logic [9:0]        init_q;
  logic              g2_q;
  logic [9:0]        chip_q;
  logic [4:0]        ms_q;
  logic              cg_rst_q, cg_rd_q, epoch_q, bit_edge_q, slew_busy_q, running_q;

  always_comb begin
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, bus.code_rate};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      hold_q      <= '0;
      init_q      <= 10'h3FF;
      g2_q        <= 1'b0;
      chip_q      <= '0;
      ms_q        <= '0;
      cg_rst_q    <= 1'b0;
      cg_rd_q     <= 1'b0;
      epoch_q     <= 1'b0;
      bit_edge_q  <= 1'b0;
      slew_busy_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        init_q <= bus.cfg_init;
        g2_q   <= bus.cfg_g2_init;
      end
      cg_rst_q   <= 1'b0;
      cg_rd_q    <= 1'b0;
      epoch_q    <= 1'b0;
      bit_edge_q <= 1'b0;

      if (state_q != StIdle && bus.stop) begin
        state_q     <= StIdle;
        slew_busy_q <= 1'b0;
        running_q   <= 1'b0;
      end else if (!bus.stop && bus.start) begin
        // Phase is cleared on entry so chip_idx reads 0 while the generator is in reset.
        state_q     <= StLoad;
        cg_rst_q    <= 1'b1;
        acc_q       <= '0;
        chip_q      <= '0;
        ms_q        <= '0;
        slew_busy_q <= 1'b0;
        running_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StLoad: begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
          StRun: begin
            acc_q <= acc_sum;
            if (carry) begin
              cg_rd_q <= 1'b1;
              if (chip_q == 10'd1022) begin
                chip_q  <= '0;
                epoch_q <= 1'b1;
                if (ms_q == 5'd19) begin
                  ms_q       <= '0;
                  bit_edge_q <= 1'b1;
                end else begin
                  ms_q <= ms_q + 5'd1;
                end
              end else begin
                chip_q <= chip_q + 10'd1;
              end
            end
            if (bus.slew_req && bus.slew_chips != '0) begin
              state_q     <= StSlew;
              hold_q      <= bus.slew_chips;
              slew_busy_q <= 1'b1;
            end
          end
          StSlew: begin
            acc_q <= acc_sum;
            if (carry) begin
              hold_q <= hold_q - SLEW_W'(1);
              if (hold_q == SLEW_W'(1)) begin
                state_q     <= StRun;
                slew_busy_q <= 1'b0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.slew_busy  = slew_busy_q;
  assign bus.cg_rst     = cg_rst_q;
  assign bus.cg_g2_init = g2_q;
  assign bus.cg_init    = init_q;
  assign bus.cg_rd      = cg_rd_q;
  assign bus.chip_idx   = chip_q;
  assign bus.epoch      = epoch_q;
  assign bus.ms_idx     = ms_q;
  assign bus.bit_edge   = bit_edge_q;
  assign bus.running    = running_q;

endmodule

// File: tb/tb_cacode_sched.sv
// Directed bench for cacode_sched: reset, start cadence, epochs/bit edge, slew, stop/restart.
module tb_cacode_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n, cnt, ep;
  logic [9:0] c;
  logic frozen;

  always #5 clk = ~clk;

  cacode_sched_if #(.NCO_W(32), .SLEW_W(10)) bus ();

  cacode_sched #(.NCO_W(32), .SLEW_W(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cg_rst"}, 32'(bus.cg_rst), 32'd0);
    chk({tag, "_cg_rd"}, 32'(bus.cg_rd), 32'd0);
    chk({tag, "_g2"}, 32'(bus.cg_g2_init), 32'd0);
    chk({tag, "_init"}, 32'(bus.cg_init), 32'h3FF);
    chk({tag, "_chip"}, 32'(bus.chip_idx), 32'd0);
    chk({tag, "_ms"}, 32'(bus.ms_idx), 32'd0);
    chk({tag, "_epoch"}, 32'(bus.epoch), 32'd0);
    chk({tag, "_bit"}, 32'(bus.bit_edge), 32'd0);
    chk({tag, "_busy"}, 32'(bus.slew_busy), 32'd0);
    chk({tag, "_running"}, 32'(bus.running), 32'd0);
  endtask

  // Waits (bounded) until cg_rd is observed high; returns cycles waited.
  task automatic wait_rd(output int cyc);
    cyc = 0;
    while (!bus.cg_rd && cyc < 20) begin
      step();
      cyc++;
    end
    chk("wait_rd_seen", 32'(bus.cg_rd), 32'd1);
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_init = '0; bus.cfg_g2_init = 0; bus.start = 0; bus.stop = 0;
    bus.code_rate = '0; bus.slew_req = 0; bus.slew_chips = '0;

    repeat (3) step();
    chk_reset("rst");
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.cg_rd) cnt++;
    end
    chk("idle_no_rd", 32'(cnt), 32'd0);

    // Configure and start at half chip rate per clk.
    bus.cfg_we = 1; bus.cfg_init = 10'h2C5; bus.cfg_g2_init = 1; bus.code_rate = 32'h8000_0000;
    step();
    bus.cfg_we = 0;
    chk("cfg_init", 32'(bus.cg_init), 32'h2C5);
    chk("cfg_g2", 32'(bus.cg_g2_init), 32'd1);
    bus.start = 1;
    step();
    bus.start = 0;
    chk("load_cg_rst", 32'(bus.cg_rst), 32'd1);
    chk("load_chip", 32'(bus.chip_idx), 32'd0);
    step();
    chk("run_cg_rst_low", 32'(bus.cg_rst), 32'd0);
    chk("run_running", 32'(bus.running), 32'd1);
    step();
    chk("first_acc_no_rd", 32'(bus.cg_rd), 32'd0);
    step();
    chk("first_rd", 32'(bus.cg_rd), 32'd1);
    chk("first_chip", 32'(bus.chip_idx), 32'd1);
    step();
    chk("rd_gap", 32'(bus.cg_rd), 32'd0);
    step();
    chk("second_rd", 32'(bus.cg_rd), 32'd1);
    chk("second_chip", 32'(bus.chip_idx), 32'd2);

    // First epoch: 1021 more ticks after chip 2.
    n = 0; c = bus.chip_idx;
    do begin
      if (!bus.epoch) c = bus.chip_idx;
      step();
      n++;
    end while (!bus.epoch && n < 3000);
    chk("epoch1_time", 32'(n), 32'd2042);
    chk("epoch1_prev_chip", 32'(c), 32'd1022);
    chk("epoch1_chip", 32'(bus.chip_idx), 32'd0);
    chk("epoch1_ms", 32'(bus.ms_idx), 32'd1);
    chk("epoch1_rd", 32'(bus.cg_rd), 32'd1);
    n = 0;
    do begin step(); n++; end while (!bus.epoch && n < 3000);
    chk("epoch_period", 32'(n), 32'd2046);
    chk("epoch2_ms", 32'(bus.ms_idx), 32'd2);

    // Bit edge on the 20th epoch.
    n = 0; ep = 2;
    do begin
      step();
      n++;
      if (bus.epoch) begin
        ep++;
        chk("ms_seq", 32'(bus.ms_idx), 32'(ep % 20));
      end
    end while (!bus.bit_edge && n < 50000);
    chk("bit_edge_time", 32'(n), 32'd36828);
    chk("bit_edge_epoch", 32'(bus.epoch), 32'd1);
    chk("bit_edge_ms", 32'(bus.ms_idx), 32'd0);
    chk("bit_edge_count", 32'(ep), 32'd20);
    step();
    chk("bit_edge_pulse", 32'(bus.bit_edge), 32'd0);

    // Slew of 5 chips requested on a tick edge.
    wait_rd(n);
    step();
    bus.slew_req = 1; bus.slew_chips = 10'd5;
    step();
    bus.slew_req = 0;
    chk("slew_tick_rd", 32'(bus.cg_rd), 32'd1);
    chk("slew_busy_set", 32'(bus.slew_busy), 32'd1);
    c = bus.chip_idx; cnt = 1; n = 0; frozen = 1'b1;
    do begin
      step();
      n++;
      if (bus.slew_busy) cnt++;
      if (!bus.cg_rd && bus.chip_idx != c) frozen = 1'b0;
    end while (!bus.cg_rd && n < 40);
    chk("slew_rd_gap", 32'(n), 32'd12);
    chk("slew_busy_cycles", 32'(cnt), 32'd10);
    chk("slew_chip_frozen", 32'(frozen), 32'd1);
    chk("slew_chip_resume", 32'(bus.chip_idx), 32'(c + 10'd1));
    step();
    step();
    chk("slew_cadence", 32'(bus.cg_rd), 32'd1);

    // Zero-length slew has no effect.
    step();
    bus.slew_req = 1; bus.slew_chips = 10'd0;
    step();
    bus.slew_req = 0;
    chk("slew0_busy", 32'(bus.slew_busy), 32'd0);
    step();
    step();
    chk("slew0_no_gap", 32'(bus.cg_rd), 32'd1);

    // stop and start together in RUN: stop wins.
    bus.stop = 1; bus.start = 1;
    step();
    bus.stop = 0; bus.start = 0;
    chk("stopstart_running", 32'(bus.running), 32'd0);
    chk("stopstart_no_rst", 32'(bus.cg_rst), 32'd0);
    c = bus.chip_idx; cnt = 0;
    bus.slew_req = 1; bus.slew_chips = 10'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.slew_req = 0;
      if (bus.cg_rd || bus.slew_busy) cnt++;
    end
    chk("idle_quiet", 32'(cnt), 32'd0);
    chk("idle_chip_hold", 32'(bus.chip_idx), 32'(c));

    // Start, slew, then stop mid-slew.
    bus.start = 1;
    step();
    bus.start = 0;
    repeat (4) step();
    bus.slew_req = 1; bus.slew_chips = 10'd5;
    step();
    bus.slew_req = 0;
    chk("slew2_busy", 32'(bus.slew_busy), 32'd1);
    bus.stop = 1;
    step();
    bus.stop = 0;
    chk("stop_slew_busy", 32'(bus.slew_busy), 32'd0);
    chk("stop_slew_running", 32'(bus.running), 32'd0);

    // Restart from RUN.
    bus.start = 1;
    step();
    bus.start = 0;
    repeat (8) step();
    chk("run_again_chip", 32'(bus.chip_idx), 32'd3);
    bus.start = 1;
    step();
    bus.start = 0;
    chk("restart_cg_rst", 32'(bus.cg_rst), 32'd1);
    chk("restart_chip", 32'(bus.chip_idx), 32'd0);

    // Asynchronous reset mid-slew.
    repeat (6) step();
    bus.slew_req = 1; bus.slew_chips = 10'd5;
    step();
    bus.slew_req = 0;
    chk("slew3_busy", 32'(bus.slew_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rd", 32'(bus.cg_rd), 32'd0);
    bus.start = 1;
    step();
    bus.start = 0;
    chk("post_rst_load", 32'(bus.cg_rst), 32'd1);
    step();
    step();
    chk("post_rst_no_rd", 32'(bus.cg_rd), 32'd0);
    step();
    chk("post_rst_first_rd", 32'(bus.cg_rd), 32'd1);
    chk("post_rst_chip1", 32'(bus.chip_idx), 32'd1);
    step();
    step();
    chk("post_rst_chip2", 32'(bus.chip_idx), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
